median_filter_1d: RTL and testbench
===================================

Name: median_filter_1d

Overview:
- Streaming 1-D sliding-window median filter for impulse-noise removal on a sample stream.
- Accepts one unsigned R_WIDTH-bit sample per clock and outputs, one per clock, the median of the last N samples.
- Sits inline in the datapath with no handshake; fixed latency.

Parameters:
- R_WIDTH, 8, sample width in bits; input and output are unsigned.
- N, 5, window length; must be odd and at least 3. Elaboration error otherwise.

Ports:
- clk  input  1  single system clock; rising edge active.
- srst  input  1  reset; asynchronous, active-high.
- X  input  R_WIDTH  input sample, captured every rising clk edge.
- Y  output  R_WIDTH  registered median of the current window.

Behaviour:
- Window: N-entry shift register win[0..N-1].
  - Each rising edge: win[0] <= X; win[i] <= win[i-1].
  - No enable; the window shifts every cycle.
- Median: combinational rank selection over win.
  - rank(i) = count of j with win[j] < win[i], plus count of j < i with win[j] == win[i].
  - Index tie-break makes all ranks unique, 0..N-1.
  - Median = the entry with rank (N-1)/2.
  - Duplicate values are handled correctly; the output is always a value present in the window.
- Output register: each rising edge, Y <= median(win) as sampled before that edge's shift.
- Latency: X presented before edge k enters the window at edge k. Its effect appears on Y after edge k+1.
  - Example: a constant input held for N+1 edges makes Y equal that constant.
- Reset (srst=1, asynchronous):
  - All win entries and Y go to 0 immediately.
  - While srst is held, X is ignored.
  - After release, the window fills from zeros. The first N-1 outputs include zero padding; no warm-up suppression in the base build.
- Reset mid-stream: same as above. All history is discarded and Y drops to 0 without waiting for a clock edge.
- Arithmetic: comparisons are unsigned only; no overflow paths.
- Timing target: 6.0 ns clock period. Comparators are compared all-pairs in one combinational stage.

Optional Feature:
- Macro: MEDIAN_FILTER_VALID_EN.
- Defined:
  - Adds output port Y_valid (1 bit, registered).
  - An internal fill counter, saturating at N, counts samples since reset.
  - Y_valid is 0 during reset and goes to 1 on the edge where Y first reflects a window of N post-reset samples, i.e. the (N+1)-th rising edge after srst release. It then stays 1 until the next reset.
  - Y behaviour is unchanged.
- Not defined: no Y_valid port and no fill counter.

Decomposition:
- Package median_filter_pkg:
  - Default constants R_WIDTH_DEF=8 and N_DEF=5.
  - Function clog2 for rank-counter width.
  - Typedef of the sample word.
- One sub-module, median_rank_select:
  - Purely combinational.
  - Input: the flattened N*R_WIDTH window. Output: the median.
  - Implements the rank computation and selection.
- The top level holds the window shift register, the output register and the optional valid logic.

Test Plan:
- Reset: srst=1 for 2 cycles with X=0 -> Y=0 throughout. Assert srst asynchronously mid-cycle with Y=200 -> Y=0 before the next edge.
- Constant: after reset, X=255 held -> Y=0 for the first 3 edges (window still majority zeros), then Y=255 from the 4th edge onward.
- Ramp: after reset, X=1,2,3,4,5 on 5 consecutive edges, then held at 5 -> Y=3 after the 6th edge, 4 after the 7th, 5 after the 8th.
- Impulse rejection: window prefilled with 10. Single-cycle X=255, then 10 -> Y stays 10 on every cycle.
- Two-cycle-held sequence (each value held 2 edges): 255,200,10,166,131,59,4,59 -> Y at every edge equals the golden-model median of the last 5 inputs.
  - Ties with duplicate values must produce a value present in the window.
- MEDIAN_FILTER_VALID_EN build:
  - Y_valid=0 for edges 1..5 after release and 1 from edge 6.
  - Re-asserting srst clears Y_valid immediately.

Source files
------------

// File: rtl/median_filter_pkg.sv
// Shared constants, sample type and width helper for the 1-D median filter.
package median_filter_pkg;

   localparam int unsigned R_WIDTH_DEF = 8;
   localparam int unsigned N_DEF       = 5;

   typedef logic [R_WIDTH_DEF-1:0] sample_t;

   // Bits needed to hold values 0..v-1; never less than 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/median_rank_select.sv
// Combinational all-pairs rank selection: returns the window entry whose
// tie-broken rank is (N-1)/2.
module median_rank_select
   import median_filter_pkg::*;
#(
   parameter int unsigned R_WIDTH = R_WIDTH_DEF,
   parameter int unsigned N       = N_DEF
) (
   input  logic [N*R_WIDTH-1:0] win_flat,
   output logic [R_WIDTH-1:0]   median_c
);

   localparam int unsigned RW  = clog2(N);
   localparam int unsigned MID = (N - 1) / 2;

   logic [R_WIDTH-1:0] w    [N];
   logic [RW-1:0]      rank [N];

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign w[g] = win_flat[g*R_WIDTH +: R_WIDTH];
   end

   // Lower index wins ties, so every entry gets a unique rank 0..N-1.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         rank[i] = '0;
         for (int j = 0; j < N; j++) begin
            if (w[j] < w[i]) begin
               rank[i] = rank[i] + RW'(1);
            end else if ((j < i) && (w[j] == w[i])) begin
               rank[i] = rank[i] + RW'(1);
            end
         end
      end
   end

   // Exactly one rank matches, so OR-ing the masked entries is a mux.
   always_comb begin
      median_c = '0;
      for (int i = 0; i < N; i++) begin
         if (rank[i] == RW'(MID)) begin
            median_c = median_c | w[i];
         end
      end
   end

endmodule

// File: rtl/median_filter_1d.sv
// Streaming sliding-window median filter: N-sample shift window, registered median.
// Optional MEDIAN_FILTER_VALID_EN adds a Y_valid flag driven by a saturating fill counter.
module median_filter_1d
   import median_filter_pkg::*;
#(
   parameter int unsigned R_WIDTH = R_WIDTH_DEF,
   parameter int unsigned N       = N_DEF
) (
   input  logic               clk,
   input  logic               srst,
   input  logic [R_WIDTH-1:0] X,
`ifdef MEDIAN_FILTER_VALID_EN
   output logic               Y_valid,
`endif
   output logic [R_WIDTH-1:0] Y
);

   if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
      $error("median_filter_1d: N must be odd and >= 3");
   end

   logic [R_WIDTH-1:0]   win [N];
   logic [N*R_WIDTH-1:0] win_flat;
   logic [R_WIDTH-1:0]   median_c;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         win_flat[i*R_WIDTH +: R_WIDTH] = win[i];
      end
   end

   median_rank_select #(
      .R_WIDTH (R_WIDTH),
      .N       (N)
   ) u_rank_select (
      .win_flat (win_flat),
      .median_c (median_c)
   );

   // Window shift and output register; Y takes the median of the pre-shift window.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         for (int i = 0; i < N; i++) begin
            win[i] <= '0;
         end
         Y <= '0;
      end else begin
         win[0] <= X;
         for (int i = 1; i < N; i++) begin
            win[i] <= win[i-1];
         end
         Y <= median_c;
      end
   end

`ifdef MEDIAN_FILTER_VALID_EN
   localparam int unsigned CW = clog2(N + 1);

   logic [CW-1:0] fill;

   // Valid rises on the edge whose Y reflects N post-reset samples.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         fill    <= '0;
         Y_valid <= 1'b0;
      end else begin
         if (fill < CW'(N)) begin
            fill <= fill + CW'(1);
         end
         Y_valid <= (fill == CW'(N));
      end
   end
`endif

endmodule

// File: tb/tb_median_filter_1d.sv
// Directed bench for median_filter_1d: table vectors plus reset and tie-heavy sequences.
module tb_median_filter_1d;
   import median_filter_pkg::*;

   localparam int unsigned NW = 5;

   logic    clk;
   logic    srst;
   sample_t X;
   sample_t Y;
`ifdef MEDIAN_FILTER_VALID_EN
   logic    Y_valid;
`endif

   int n_total;
   int n_pass;
   int edges_since_rst;

   median_filter_1d #(.R_WIDTH(8), .N(NW)) dut (
      .clk     (clk),
      .srst    (srst),
      .X       (X),
`ifdef MEDIAN_FILTER_VALID_EN
      .Y_valid (Y_valid),
`endif
      .Y       (Y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic    do_rst;
      sample_t x;
      sample_t y;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reset asserted mid-cycle, held over one edge, released on a falling edge.
   task automatic do_reset();
      @(negedge clk);
      srst = 1'b1;
      X    = 8'd0;
      #1;
      check("rst_async_y", int'(Y), 0);
      @(posedge clk);
      #1;
      check("rst_held_y", int'(Y), 0);
      @(negedge clk);
      srst = 1'b0;
      edges_since_rst = 0;
   endtask

   task automatic step(input sample_t x_in);
      X = x_in;
      @(posedge clk);
      #1;
      edges_since_rst++;
`ifdef MEDIAN_FILTER_VALID_EN
      check("y_valid", int'(Y_valid), (edges_since_rst >= 6) ? 1 : 0);
`endif
   endtask

   function automatic sample_t med5(input sample_t h[NW]);
      sample_t s[NW];
      sample_t t;
      for (int i = 0; i < NW; i++) s[i] = h[i];
      for (int i = 0; i < NW; i++) begin
         for (int j = 0; j < NW - 1 - i; j++) begin
            if (s[j] > s[j+1]) begin
               t = s[j]; s[j] = s[j+1]; s[j+1] = t;
            end
         end
      end
      return s[NW/2];
   endfunction

   vec_t vecs[$];

   initial begin
      sample_t hist[NW];
      sample_t held[8];
      sample_t exp_y;

      n_total = 0;
      n_pass  = 0;
      edges_since_rst = 0;
      srst = 1'b1;
      X    = 8'd0;

      // Power-on reset held for 2 edges with X=0.
      #1;
      check("por_y", int'(Y), 0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("por_held_y", int'(Y), 0);
`ifdef MEDIAN_FILTER_VALID_EN
         check("por_valid", int'(Y_valid), 0);
`endif
      end
      @(negedge clk);
      srst = 1'b0;

      // Constant 255: majority-zero window for 3 edges.
      vecs.push_back('{1'b1, 8'd255, 8'd0});
      vecs.push_back('{1'b0, 8'd255, 8'd0});
      vecs.push_back('{1'b0, 8'd255, 8'd0});
      vecs.push_back('{1'b0, 8'd255, 8'd255});
      vecs.push_back('{1'b0, 8'd255, 8'd255});
      vecs.push_back('{1'b0, 8'd255, 8'd255});
      vecs.push_back('{1'b0, 8'd255, 8'd255});
      // Ramp 1..5 then hold 5.
      vecs.push_back('{1'b1, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 8'd2, 8'd0});
      vecs.push_back('{1'b0, 8'd3, 8'd0});
      vecs.push_back('{1'b0, 8'd4, 8'd1});
      vecs.push_back('{1'b0, 8'd5, 8'd2});
      vecs.push_back('{1'b0, 8'd5, 8'd3});
      vecs.push_back('{1'b0, 8'd5, 8'd4});
      vecs.push_back('{1'b0, 8'd5, 8'd5});
      // Prefill with 10, then a single-cycle 255 impulse.
      vecs.push_back('{1'b1, 8'd10, 8'd0});
      vecs.push_back('{1'b0, 8'd10, 8'd0});
      vecs.push_back('{1'b0, 8'd10, 8'd0});
      vecs.push_back('{1'b0, 8'd10, 8'd10});
      vecs.push_back('{1'b0, 8'd10, 8'd10});
      vecs.push_back('{1'b0, 8'd10, 8'd10});
      vecs.push_back('{1'b0, 8'd255, 8'd10});
      vecs.push_back('{1'b0, 8'd10, 8'd10});
      vecs.push_back('{1'b0, 8'd10, 8'd10});
      vecs.push_back('{1'b0, 8'd10, 8'd10});
      vecs.push_back('{1'b0, 8'd10, 8'd10});
      vecs.push_back('{1'b0, 8'd10, 8'd10});
      vecs.push_back('{1'b0, 8'd10, 8'd10});

      foreach (vecs[k]) begin
         if (vecs[k].do_rst) do_reset();
         step(vecs[k].x);
         check($sformatf("vec%0d_y", k), int'(Y), int'(vecs[k].y));
      end

      // Mid-stream asynchronous reset with Y at 200.
      do_reset();
      repeat (4) step(8'd200);
      check("pre_async_y", int'(Y), 200);
      #3;
      srst = 1'b1;
      #1;
      check("async_mid_y", int'(Y), 0);
`ifdef MEDIAN_FILTER_VALID_EN
      check("async_mid_valid", int'(Y_valid), 0);
`endif
      @(posedge clk);
      #1;
      check("async_held_y", int'(Y), 0);
      @(negedge clk);
      srst = 1'b0;
      edges_since_rst = 0;

      // Each value held two edges; reference median by sorting the last 5 inputs.
      held[0] = 8'd255; held[1] = 8'd200; held[2] = 8'd10;  held[3] = 8'd166;
      held[4] = 8'd131; held[5] = 8'd59;  held[6] = 8'd4;   held[7] = 8'd59;
      for (int i = 0; i < NW; i++) hist[i] = 8'd0;
      for (int k = 0; k < 20; k++) begin
         sample_t xv;
         xv = (k < 16) ? held[k/2] : 8'd59;
         exp_y = med5(hist);
         step(xv);
         check($sformatf("held%0d_y", k), int'(Y), int'(exp_y));
         for (int i = NW - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = xv;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
